// File: rtl/loss_head_if.sv
// Handshake bundle between loss_head and its controller / the last down3 layer.
interface loss_head_if #(
   parameter int N = 9
);
   localparam int EW = $clog2(N + 1);

   logic          start;
   logic [N-1:0]  target;
   logic [N-1:0]  fout;
   logic          fd_prop_done;
   logic          bk_prop_done;
   logic          fd_prop;
   logic          bk_prop;
   logic [N-1:0]  bin;
   logic [N-1:0]  decision;
   logic [EW-1:0] err_count;
   logic          busy;
   logic          done;
   logic          timeout;

   modport master (
      output start, target, fout, fd_prop_done, bk_prop_done,
      input  fd_prop, bk_prop, bin, decision, err_count, busy, done, timeout
   );

   modport slave (
      input  start, target, fout, fd_prop_done, bk_prop_done,
      output fd_prop, bk_prop, bin, decision, err_count, busy, done, timeout
   );
endinterface

// File: rtl/loss_head.sv
// Loss stage behind the last down3 layer: samples the forward pass SAMPLES times,
// majority-votes each bit, compares with a latched target and starts backprop.
module loss_head #(
   parameter int N       = 9,
   parameter int SAMPLES = 16,
   parameter int TIMEOUT = 64
) (
   input  logic       clk_in,
   input  logic       rst_in,
   loss_head_if.slave bus
);
   localparam int CW = $clog2(SAMPLES + 1);
   localparam int EW = $clog2(N + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [CW:0]   SAMP_CMP = (CW + 1)'(SAMPLES);
   localparam logic [CW-1:0] LAST_SMP = CW'(SAMPLES - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FWD_ISSUE = 3'd1,
      FWD_WAIT  = 3'd2,
      VOTE      = 3'd3,
      BK_ISSUE  = 3'd4,
      BK_WAIT   = 3'd5,
      FINISH    = 3'd6
   } state_t;

   state_t        state_q;
   logic [N-1:0]  target_q;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] smp_q;
   logic [WW-1:0] wd_q;
   logic          fd_prop_q;
   logic          bk_prop_q;
   logic [N-1:0]  bin_q;
   logic [N-1:0]  decision_q;
   logic [EW-1:0] err_count_q;
   logic          busy_q;
   logic          done_q;
   logic          timeout_q;

   logic [N-1:0]  vote_d;
   logic [N-1:0]  bin_d;
   logic [EW-1:0] err_d;

   function automatic logic [EW-1:0] popcount(input logic [N-1:0] v);
      logic [EW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + EW'(v[i]);
      end
      return c;
   endfunction

   // Majority vote: a bit wins only with strictly more than half the passes, so ties vote 0.
   always_comb begin
      vote_d = '0;
      for (int i = 0; i < N; i++) begin
         vote_d[i] = ({cnt_q[i], 1'b0} > SAMP_CMP);
      end
      bin_d = vote_d ^ target_q;
      err_d = popcount(bin_d);
   end

   // Train-step sequencer; every output is registered here.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         target_q    <= '0;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
         smp_q       <= '0;
         wd_q        <= '0;
         fd_prop_q   <= 1'b0;
         bk_prop_q   <= 1'b0;
         bin_q       <= '0;
         decision_q  <= '0;
         err_count_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         fd_prop_q <= 1'b0;
         bk_prop_q <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  target_q <= bus.target;
                  for (int i = 0; i < N; i++) begin
                     cnt_q[i] <= '0;
                  end
                  smp_q     <= '0;
                  fd_prop_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= FWD_ISSUE;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            FWD_ISSUE: begin
               wd_q    <= '0;
               state_q <= FWD_WAIT;
            end
            FWD_WAIT: begin
               if (bus.fd_prop_done) begin
                  for (int i = 0; i < N; i++) begin
                     cnt_q[i] <= cnt_q[i] + CW'(bus.fout[i]);
                  end
                  smp_q <= smp_q + CW'(1);
                  if (smp_q == LAST_SMP) begin
                     state_q <= VOTE;
                  end else begin
                     fd_prop_q <= 1'b1;
                     state_q   <= FWD_ISSUE;
                  end
               end else if (wd_q == WD_LAST) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  wd_q <= wd_q + WW'(1);
               end
            end
            VOTE: begin
               decision_q  <= vote_d;
               bin_q       <= bin_d;
               err_count_q <= err_d;
               bk_prop_q   <= 1'b1;
               state_q     <= BK_ISSUE;
            end
            BK_ISSUE: begin
               wd_q    <= '0;
               state_q <= BK_WAIT;
            end
            BK_WAIT: begin
               if (bus.bk_prop_done) begin
                  done_q  <= 1'b1;
                  state_q <= FINISH;
               end else if (wd_q == WD_LAST) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  wd_q <= wd_q + WW'(1);
               end
            end
            FINISH: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.fd_prop   = fd_prop_q;
   assign bus.bk_prop   = bk_prop_q;
   assign bus.bin       = bin_q;
   assign bus.decision  = decision_q;
   assign bus.err_count = err_count_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_loss_head.sv
// Randomized bench for loss_head: emulates the down3 handshake and checks each
// train step against a vote computed directly from the forward-pass patterns.
module tb_loss_head;
   localparam int N       = 9;
   localparam int SAMPLES = 16;
   localparam int TIMEOUT = 64;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [N-1:0] pat [SAMPLES];
   logic [N-1:0] m_dec = '0;
   logic [N-1:0] m_bin = '0;
   int           m_err = 0;

   loss_head_if #(.N(N)) bus ();

   loss_head #(.N(N), .SAMPLES(SAMPLES), .TIMEOUT(TIMEOUT)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_fd"},   32'(bus.fd_prop),   32'd0);
      chk({tag, "_bk"},   32'(bus.bk_prop),   32'd0);
      chk({tag, "_bin"},  32'(bus.bin),       32'd0);
      chk({tag, "_dec"},  32'(bus.decision),  32'd0);
      chk({tag, "_err"},  32'(bus.err_count), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy),      32'd0);
      chk({tag, "_done"}, 32'(bus.done),      32'd0);
      chk({tag, "_to"},   32'(bus.timeout),   32'd0);
   endtask

   task automatic fill_random();
      for (int p = 0; p < SAMPLES; p++) begin
         pat[p] = N'($urandom);
      end
   endtask

   // bit0 set on exactly k passes, in a shuffled order
   task automatic fill_bit0(input int k);
      logic [N-1:0] t;
      int j;
      fill_random();
      for (int p = 0; p < SAMPLES; p++) begin
         pat[p][0] = (p < k);
      end
      for (int i = SAMPLES - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = pat[i]; pat[i] = pat[j]; pat[j] = t;
      end
   endtask

   // mode 0: normal step, 1: drop fd_prop_done on pass drop_idx, 2: reset during BK_WAIT
   task automatic run_step(input logic [N-1:0] tgt, input int mode, input int drop_idx, input bit strays);
      int n_fd = 0, n_bk = 0, n_done = 0, n_to = 0, n_both = 0;
      int pass = 0, cd_fd = 0, cd_bk = 0, rst_cd = 0, cyc = 0, drop_cyc = 0, to_gap = 0, sum;
      bit fin = 0, rst_fired = 0;
      logic [N-1:0] e_dec, e_bin, prev_dec, prev_bin;
      prev_dec = m_dec;
      prev_bin = m_bin;
      for (int b = 0; b < N; b++) begin
         sum = 0;
         for (int p = 0; p < SAMPLES; p++) sum += int'(pat[p][b]);
         e_dec[b] = (2 * sum > SAMPLES);
      end
      e_bin = e_dec ^ tgt;

      bus.start  = 1'b1;
      bus.target = tgt;
      @(negedge clk_in);
      bus.target = N'($urandom);
      chk("busy_on_start", 32'(bus.busy), 32'd1);

      while (!fin && cyc < 3000) begin
         cyc++;
         if (bus.fd_prop) n_fd++;
         if (bus.bk_prop) begin
            n_bk++;
            chk("bin_at_bk", 32'(bus.bin), 32'(e_bin));
         end
         if (bus.fd_prop && bus.bk_prop) n_both++;
         if (bus.done) begin n_done++; fin = 1; end
         if (bus.timeout) begin n_to++; fin = 1; to_gap = cyc - drop_cyc; end

         bus.start = 1'b0;
         bus.fd_prop_done = 1'b0;
         bus.bk_prop_done = 1'b0;
         bus.fout = N'($urandom);

         if (rst_fired) begin
            check_zero("mid_rst");
            rst_in = 1'b0;
            fin = 1;
         end else if (rst_cd > 0) begin
            rst_cd--;
            if (rst_cd == 0) begin rst_in = 1'b1; rst_fired = 1; end
         end

         if (cd_fd > 0) begin
            cd_fd--;
            if (cd_fd == 0) begin
               bus.fd_prop_done = 1'b1;
               bus.fout = pat[pass];
               pass++;
            end
         end else if (strays && pass == SAMPLES && $urandom_range(0, 3) == 0) begin
            bus.fd_prop_done = 1'b1;
         end

         if (cd_bk > 0) begin
            cd_bk--;
            if (cd_bk == 0) bus.bk_prop_done = 1'b1;
         end else if (strays && pass < SAMPLES && $urandom_range(0, 3) == 0) begin
            bus.bk_prop_done = 1'b1;
         end

         if (bus.fd_prop) begin
            if (mode == 1 && pass == drop_idx) drop_cyc = cyc;
            else cd_fd = $urandom_range(1, 3);
         end
         if (bus.bk_prop) begin
            if (mode == 2) rst_cd = 1;
            else cd_bk = $urandom_range(1, 3);
         end

         if (strays && !bus.timeout && !rst_fired && !rst_in &&
             (bus.done || $urandom_range(0, 2) == 0)) begin
            bus.start = 1'b1;
         end
         @(negedge clk_in);
      end

      bus.start = 1'b0;
      bus.fd_prop_done = 1'b0;
      bus.bk_prop_done = 1'b0;
      chk("step_ended", 32'(fin), 32'd1);
      chk("idle_after", 32'(bus.busy), 32'd0);
      chk("no_done_after", 32'(bus.done), 32'd0);
      chk("no_overlap", 32'(n_both), 32'd0);
      case (mode)
         0: begin
            chk("fd_count", 32'(n_fd), 32'(SAMPLES));
            chk("bk_count", 32'(n_bk), 32'd1);
            chk("done_count", 32'(n_done), 32'd1);
            chk("to_count", 32'(n_to), 32'd0);
            chk("decision", 32'(bus.decision), 32'(e_dec));
            chk("bin", 32'(bus.bin), 32'(e_bin));
            chk("err_count", 32'(bus.err_count), 32'($countones(e_bin)));
            m_dec = e_dec;
            m_bin = e_bin;
            m_err = $countones(e_bin);
         end
         1: begin
            chk("fd_count_to", 32'(n_fd), 32'(drop_idx + 1));
            chk("bk_count_to", 32'(n_bk), 32'd0);
            chk("done_count_to", 32'(n_done), 32'd0);
            chk("to_count", 32'(n_to), 32'd1);
            chk("to_gap_ok", 32'(to_gap >= TIMEOUT && to_gap <= TIMEOUT + 2), 32'd1);
            chk("dec_kept", 32'(bus.decision), 32'(prev_dec));
            chk("bin_kept", 32'(bus.bin), 32'(prev_bin));
            chk("err_kept", 32'(bus.err_count), 32'(m_err));
         end
         default: begin
            chk("fd_count_rst", 32'(n_fd), 32'(SAMPLES));
            chk("bk_count_rst", 32'(n_bk), 32'd1);
            chk("done_count_rst", 32'(n_done), 32'd0);
            chk("to_count_rst", 32'(n_to), 32'd0);
            chk("bin_rst", 32'(bus.bin), 32'd0);
            m_dec = '0;
            m_bin = '0;
            m_err = 0;
         end
      endcase
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit got=expired exp=finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [N-1:0] tgt;
      bus.start = 1'b0;
      bus.target = '0;
      bus.fout = '0;
      bus.fd_prop_done = 1'b0;
      bus.bk_prop_done = 1'b0;
      rst_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check_zero("reset");
      rst_in = 1'b0;

      // all-ones forward output against a 0F0 target
      for (int p = 0; p < SAMPLES; p++) pat[p] = 9'h1FF;
      run_step(9'h0F0, 0, 0, 1'b0);
      chk("ex_decision", 32'(bus.decision), 32'h1FF);
      chk("ex_bin", 32'(bus.bin), 32'h10F);
      chk("ex_err", 32'(bus.err_count), 32'd5);

      // exact tie votes 0, one above half votes 1
      fill_bit0(SAMPLES / 2);
      tgt = N'($urandom) & 9'h1FE;
      run_step(tgt, 0, 0, 1'b0);
      chk("tie_dec0", 32'(bus.decision[0]), 32'd0);
      chk("tie_bin0", 32'(bus.bin[0]), 32'd0);
      fill_bit0(SAMPLES / 2 + 1);
      tgt = N'($urandom) & 9'h1FE;
      run_step(tgt, 0, 0, 1'b0);
      chk("maj_dec0", 32'(bus.decision[0]), 32'd1);
      chk("maj_bin0", 32'(bus.bin[0]), 32'd1);

      fill_random();
      run_step(N'($urandom), 1, 4, 1'b0);

      fill_random();
      run_step(N'($urandom), 2, 0, 1'b0);
      fill_random();
      run_step(N'($urandom), 0, 0, 1'b0);

      for (int s = 0; s < 8; s++) begin
         fill_random();
         run_step(N'($urandom), 0, 0, 1'(s % 2 == 0));
      end

      fill_random();
      run_step(N'($urandom), 1, $urandom_range(0, SAMPLES - 1), 1'b1);
      fill_random();
      run_step(N'($urandom), 0, 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
